// File: rtl/writeback_stage_reg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg / writeback_stage_reg
//
// Purpose:
//   Memory-access stage plus the MEM/WB pipeline register of the rv32i
//   5-stage core. The stage performs byte/half/word loads and stores on a
//   word-organised internal data memory. It then registers the selected
//   writeback value and control for the register file.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   stall_i, flush_i      hazard-unit controls (flush has priority)
//   regwriteM             register-file write enable of the M instruction
//   resultsrcM            0 = ALU result, 1 = load data
//   memwriteM             store enable
//   funct3M               RV32I load/store size/sign encoding
//   aluresultM            effective address / ALU result
//   Rd2M                  store data
//   RdM                   destination register
//   regwriteW, RdW,
//   resultW, misalignW    registered writeback outputs
//   readdataM             combinational extracted load data
//
// Pipeline control (the one rule all stage controls follow):
//   The W register captures the M-stage values on every rising edge where
//   rst_n=1, stall_i=0 and flush_i=0. With stall_i=1 the W register holds.
//   With flush_i=1 the W register loads an all-zero bubble, whatever the
//   value of stall_i. A store commits only on an edge where the W register
//   would capture and the access is aligned. A stalled or flushed store is
//   therefore never written to memory.
// ---------------------------------------------------------------------------
package rv32i_pkg;
  localparam int DPW = 32;
endpackage

module writeback_stage_reg
  import rv32i_pkg::*;
#(
  parameter  int MEM_DEPTH = 256,
  localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stall_i,
  input  logic           flush_i,
  input  logic           regwriteM,
  input  logic           resultsrcM,
  input  logic           memwriteM,
  input  logic [2:0]     funct3M,
  input  logic [DPW-1:0] aluresultM,
  input  logic [DPW-1:0] Rd2M,
  input  logic [4:0]     RdM,
  output logic           regwriteW,
  output logic [4:0]     RdW,
  output logic [DPW-1:0] resultW,
  output logic           misalignW,
  output logic [DPW-1:0] readdataM
);

  // -------------------------------------------------------------------------
  // Data memory (not reset)
  // -------------------------------------------------------------------------
  logic [DPW-1:0] mem_q [MEM_DEPTH];

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        off;
  logic [DPW-1:0]    mem_word;
  logic              is_half;
  logic              is_word;
  logic              mis;

  // Address bits above the memory window are deliberately dropped.
  // Addresses therefore wrap modulo 4*MEM_DEPTH.
  logic unused_addr_bits;
  assign unused_addr_bits = ^aluresultM[DPW-1:ADDR_W+2];

  assign word_idx = aluresultM[ADDR_W+1:2];
  assign off      = aluresultM[1:0];
  assign mem_word = mem_q[word_idx];
  assign is_half  = (funct3M[1:0] == 2'b01);
  assign is_word  = (funct3M[1:0] == 2'b10);

  // Alignment is only meaningful for real memory accesses. ALU-only
  // instructions never flag misalignment, even when the address looks odd.
  assign mis = (memwriteM | resultsrcM) &
               ((is_half & off[0]) | (is_word & (off != 2'b00)));

  // -------------------------------------------------------------------------
  // Load extraction
  // -------------------------------------------------------------------------
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    load_byte = 8'h00;
    unique case (off)
      2'd0: load_byte = mem_word[7:0];
      2'd1: load_byte = mem_word[15:8];
      2'd2: load_byte = mem_word[23:16];
      2'd3: load_byte = mem_word[31:24];
      default: load_byte = 8'h00;
    endcase
  end

  assign load_half = off[1] ? mem_word[31:16] : mem_word[15:0];

  // The read uses the pre-edge memory contents. A same-word store in this
  // cycle is therefore not seen until the next cycle.
  always_comb begin
    readdataM = '0;
    if (!mis) begin
      case (funct3M)
        3'b000:  readdataM = {{24{load_byte[7]}}, load_byte};
        3'b001:  readdataM = {{16{load_half[15]}}, load_half};
        3'b010:  readdataM = mem_word;
        3'b100:  readdataM = {24'h000000, load_byte};
        3'b101:  readdataM = {16'h0000, load_half};
        default: readdataM = '0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Store lane generation
  // -------------------------------------------------------------------------
  logic           wr_en;
  logic [3:0]     wr_mask;
  logic [DPW-1:0] wr_data;

  assign wr_en = memwriteM & rst_n & ~stall_i & ~flush_i & ~mis;

  // Store data is replicated across lanes. The lane mask alone then picks
  // the destination bytes, so no shifter is needed.
  always_comb begin
    wr_mask = 4'b0000;
    wr_data = '0;
    case (funct3M)
      3'b000: begin
        wr_mask = 4'b0001 << off;
        wr_data = {4{Rd2M[7:0]}};
      end
      3'b001: begin
        wr_mask = off[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{Rd2M[15:0]}};
      end
      3'b010: begin
        wr_mask = 4'b1111;
        wr_data = Rd2M;
      end
      default: begin
        wr_mask = 4'b0000;
        wr_data = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (wr_mask[lane]) begin
          mem_q[word_idx][lane*8 +: 8] <= wr_data[lane*8 +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Result selection and W register
  // -------------------------------------------------------------------------
  logic [DPW-1:0] result_m;

  logic           regwrite_d, regwrite_q;
  logic [4:0]     rd_d, rd_q;
  logic [DPW-1:0] result_d, result_q;
  logic           misalign_d, misalign_q;

  assign result_m = resultsrcM ? readdataM : aluresultM;

  always_comb begin
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    result_d   = result_q;
    misalign_d = misalign_q;
    if (flush_i) begin
      regwrite_d = 1'b0;
      rd_d       = 5'd0;
      result_d   = '0;
      misalign_d = 1'b0;
    end else if (!stall_i) begin
      // A misaligned access must never update the register file.
      regwrite_d = regwriteM & ~mis;
      rd_d       = RdM;
      result_d   = result_m;
      misalign_d = mis;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwrite_q <= 1'b0;
      rd_q       <= 5'd0;
      result_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      misalign_q <= misalign_d;
    end
  end

  assign regwriteW = regwrite_q;
  assign RdW       = rd_q;
  assign resultW   = result_q;
  assign misalignW = misalign_q;

endmodule

// File: tb/tb_writeback_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage_reg
//
// Directed and short random testbench for writeback_stage_reg. The bench
// keeps its own model of the data memory and the W register. Each step
// pushes the expected W values and pops them one edge later.
// ---------------------------------------------------------------------------
module tb_writeback_stage_reg;

  typedef struct packed {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        mis;
  } w_t;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic        regwriteM;
  logic        resultsrcM;
  logic        memwriteM;
  logic [2:0]  funct3M;
  logic [31:0] aluresultM;
  logic [31:0] Rd2M;
  logic [4:0]  RdM;
  logic        regwriteW;
  logic [4:0]  RdW;
  logic [31:0] resultW;
  logic        misalignW;
  logic [31:0] readdataM;

  always #5 clk = ~clk;

  writeback_stage_reg #(.MEM_DEPTH(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .regwriteM  (regwriteM),
    .resultsrcM (resultsrcM),
    .memwriteM  (memwriteM),
    .funct3M    (funct3M),
    .aluresultM (aluresultM),
    .Rd2M       (Rd2M),
    .RdM        (RdM),
    .regwriteW  (regwriteW),
    .RdW        (RdW),
    .resultW    (resultW),
    .misalignW  (misalignW),
    .readdataM  (readdataM)
  );

  // -------------------------------------------------------------------------
  // Scoreboard and model state
  // -------------------------------------------------------------------------
  w_t          exp_q[$];
  w_t          w_model = '0;
  logic [31:0] m_mem [256];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference load, written from the RV32I load semantics.
  task automatic model_load(input logic mw, input logic rs, input logic [2:0] f3,
                            input logic [31:0] addr,
                            output logic [31:0] data, output logic mis);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    logic [1:0]  o;
    o   = addr[1:0];
    w   = m_mem[addr[9:2]];
    b   = 8'((w >> (8 * int'(o))) & 32'hFF);
    h   = o[1] ? w[31:16] : w[15:0];
    mis = (mw | rs) & (((f3[1:0] == 2'b01) & o[0]) | ((f3[1:0] == 2'b10) & (o != 2'b00)));
    case (f3)
      3'b000:  data = {{24{b[7]}}, b};
      3'b001:  data = {{16{h[15]}}, h};
      3'b010:  data = w;
      3'b100:  data = {24'h0, b};
      3'b101:  data = {16'h0, h};
      default: data = 32'h0;
    endcase
    if (mis) data = 32'h0;
  endtask

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] d);
    int idx;
    idx = int'(addr[9:2]);
    case (f3)
      3'b000:  m_mem[idx][8*int'(addr[1:0]) +: 8] = d[7:0];
      3'b001:  m_mem[idx][16*int'(addr[1]) +: 16] = d[15:0];
      3'b010:  m_mem[idx] = d;
      default: ;
    endcase
  endtask

  // -------------------------------------------------------------------------
  // Driver: one M-stage instruction per cycle
  // -------------------------------------------------------------------------
  task automatic step(input logic mw, input logic rs, input logic rw,
                      input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] data, input logic [4:0] rd);
    logic [31:0] ld;
    logic        mis;
    w_t          nxt;
    w_t          got;
    @(negedge clk);
    memwriteM  = mw;
    resultsrcM = rs;
    regwriteM  = rw;
    funct3M    = f3;
    aluresultM = addr;
    Rd2M       = data;
    RdM        = rd;
    model_load(mw, rs, f3, addr, ld, mis);
    #1;
    if (rs) chk("readdataM", readdataM, ld);
    if (!rst_n || flush_i) begin
      nxt = '0;
    end else if (stall_i) begin
      nxt = w_model;
    end else begin
      nxt.rw  = rw & ~mis;
      nxt.rd  = rd;
      nxt.res = rs ? ld : addr;
      nxt.mis = mis;
    end
    exp_q.push_back(nxt);
    if (rst_n && !stall_i && !flush_i && mw && !mis) model_store(f3, addr, data);
    w_model = nxt;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      got = exp_q.pop_front();
      chk("regwriteW", {31'h0, regwriteW}, {31'h0, got.rw});
      chk("RdW",       {27'h0, RdW},       {27'h0, got.rd});
      chk("resultW",   resultW,            got.res);
      chk("misalignW", {31'h0, misalignW}, {31'h0, got.mis});
    end
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, 1'b0, 3'b010, a, d, 5'd0);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
    step(1'b0, 1'b1, 1'b1, f3, a, 32'h0, rd);
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence, then a short random run
  // -------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    regwriteM = 1'b0; resultsrcM = 1'b0; memwriteM = 1'b0;
    funct3M = 3'b000; aluresultM = 32'h0; Rd2M = 32'h0; RdM = 5'd0;
    for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;

    // Reset state; then a store under reset must not reach memory.
    step(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    rst_n = 1'b1;
    sw(32'h40, 32'h1111_1111);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 1'b1, 3'b010, 32'h40, 32'h2222_2222, 5'd4);
    step(1'b1, 1'b0, 1'b1, 3'b010, 32'h40, 32'h2222_2222, 5'd4);
    chk("reset_resultW", resultW, 32'h0);
    chk("reset_regwriteW", {31'h0, regwriteW}, 32'h0);
    rst_n = 1'b1;
    ld(3'b010, 32'h40, 5'd3);
    chk("reset_mem_kept", resultW, 32'h1111_1111);

    // SW then LW
    sw(32'h10, 32'hDEAD_BEEF);
    ld(3'b010, 32'h10, 5'd5);
    chk("lw_result", resultW, 32'hDEAD_BEEF);
    chk("lw_rd", {27'h0, RdW}, 32'd5);
    chk("lw_regwrite", {31'h0, regwriteW}, 32'd1);

    // Byte/half extraction
    sw(32'h80, 32'h80FF_7F01);
    ld(3'b000, 32'h83, 5'd6);  chk("lb_0x83",  resultW, 32'hFFFF_FF80);
    ld(3'b100, 32'h83, 5'd6);  chk("lbu_0x83", resultW, 32'h0000_0080);
    ld(3'b001, 32'h82, 5'd6);  chk("lh_0x82",  resultW, 32'hFFFF_80FF);
    ld(3'b101, 32'h80, 5'd6);  chk("lhu_0x80", resultW, 32'h0000_7F01);

    // Sub-word stores over a zeroed word
    sw(32'h80, 32'h0);
    step(1'b1, 1'b0, 1'b0, 3'b000, 32'h81, 32'h0000_00AA, 5'd0);
    step(1'b1, 1'b0, 1'b0, 3'b001, 32'h82, 32'h0000_1234, 5'd0);
    ld(3'b010, 32'h80, 5'd8);  chk("subword_merge", resultW, 32'h1234_AA00);

    // Misaligned accesses
    sw(32'h20, 32'hCAFE_F00D);
    step(1'b1, 1'b0, 1'b1, 3'b010, 32'h22, 32'h1234_5678, 5'd0);
    chk("sw_mis_flag", {31'h0, misalignW}, 32'd1);
    chk("sw_mis_regwrite", {31'h0, regwriteW}, 32'd0);
    ld(3'b010, 32'h20, 5'd9);  chk("sw_mis_no_write", resultW, 32'hCAFE_F00D);
    ld(3'b001, 32'h21, 5'd9);
    chk("lh_mis_result", resultW, 32'h0);
    chk("lh_mis_regwrite", {31'h0, regwriteW}, 32'd0);
    chk("lh_mis_flag", {31'h0, misalignW}, 32'd1);

    // Stall / flush with a pending store
    ld(3'b010, 32'h10, 5'd7);
    stall_i = 1'b1;
    step(1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'h9999_9999, 5'd9);
    chk("stall_hold", resultW, 32'hDEAD_BEEF);
    flush_i = 1'b1;
    step(1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'h9999_9999, 5'd9);
    chk("flush_rd", {27'h0, RdW}, 32'd0);
    stall_i = 1'b0; flush_i = 1'b0;
    ld(3'b010, 32'h10, 5'd7);  chk("stall_flush_no_write", resultW, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'h9999_9999, 5'd9);
    ld(3'b010, 32'h10, 5'd7);  chk("store_commit", resultW, 32'h9999_9999);

    // Read-during-write to the same word returns the old contents
    step(1'b1, 1'b1, 1'b1, 3'b010, 32'h10, 32'h7777_7777, 5'd2);
    chk("rdw_old", resultW, 32'h9999_9999);
    ld(3'b010, 32'h10, 5'd2);  chk("rdw_new", resultW, 32'h7777_7777);

    // Address wrap: 0x410 aliases 0x10
    ld(3'b010, 32'h0000_0410, 5'd1);  chk("addr_wrap", resultW, 32'h7777_7777);

    // Random mix over an initialised window
    for (int i = 0; i < 16; i++) sw(32'h100 + 32'(i * 4), $urandom());
    for (int i = 0; i < 60; i++) begin
      stall_i = ($urandom_range(0, 7) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 32'h100 + 32'($urandom_range(0, 63)),
           $urandom(), 5'($urandom_range(0, 31)));
    end
    stall_i = 1'b0; flush_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
